// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU op classes, R-type function codes and the hardwired zero register.
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;
  localparam logic [5:0] FUNC_SLL = 6'b000000;
  localparam logic [5:0] FUNC_SRL = 6'b000010;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_select.sv
// Operand forward mux: EX/MEM result beats MEM/WB data beats the latched value; $0 never forwards.
// Purely combinational, no flow control.
module fwd_select
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] src_i,
  input  logic [WIDTH-1:0] latched_i,
  input  logic             exm_reg_write_i,
  input  logic [RADDR-1:0] exm_rd_i,
  input  logic [WIDTH-1:0] exm_result_i,
  input  logic             wb_reg_write_i,
  input  logic [RADDR-1:0] wb_rd_i,
  input  logic [WIDTH-1:0] wb_data_i,
  output logic [WIDTH-1:0] fwd_o
);

  logic exm_hit, wb_hit;

  assign exm_hit = exm_reg_write_i && (exm_rd_i != RADDR'(REG_ZERO)) && (exm_rd_i == src_i);
  assign wb_hit  = wb_reg_write_i  && (wb_rd_i  != RADDR'(REG_ZERO)) && (wb_rd_i  == src_i);

  always_comb begin
    fwd_o = latched_i;
    if (exm_hit)     fwd_o = exm_result_i;
    else if (wb_hit) fwd_o = wb_data_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding and load-use stall; 1-cycle latency, stall holds upstream.
// Optional perf counters (perf_stalls, perf_flushes) under macro ID_EX_PERF_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_shamt,
  input  logic [5:0]       id_func,
  input  logic [1:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             flush,
  input  logic             exm_reg_write,
  input  logic [RADDR-1:0] exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             wb_reg_write,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             stall,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_in1,
  output logic [WIDTH-1:0] ex_in2,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [4:0]       ex_shamt,
  output logic [5:0]       ex_func,
  output logic [1:0]       ex_alu_op,
  output logic [RADDR-1:0] ex_wr_reg,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]      perf_stalls,
  output logic [31:0]      perf_flushes
`endif
);

  logic             valid_q, valid_d;
  logic [RADDR-1:0] rs_q, rs_d, rt_q, rt_d, wr_reg_q, wr_reg_d;
  logic [WIDTH-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [4:0]       shamt_q, shamt_d;
  logic [5:0]       func_q, func_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             alu_src_q, alu_src_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic             reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;
  logic [WIDTH-1:0] fwd_rs, fwd_rt;

  // A load in EX cannot forward its data yet; hold the dependent in ID for one cycle.
  assign stall = !reset && mem_read_q && valid_q && id_valid && !flush
                 && (wr_reg_q != RADDR'(REG_ZERO))
                 && ((wr_reg_q == id_rs) || (wr_reg_q == id_rt));

  always_comb begin
    valid_d      = 1'b0;
    rs_d         = '0;
    rt_d         = '0;
    wr_reg_d     = '0;
    rs_data_d    = '0;
    rt_data_d    = '0;
    imm_d        = '0;
    shamt_d      = '0;
    func_d       = '0;
    alu_op_d     = '0;
    alu_src_d    = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    if (!flush && !stall) begin
      valid_d      = id_valid;
      rs_d         = id_rs;
      rt_d         = id_rt;
      wr_reg_d     = id_reg_dst ? id_rd : id_rt;
      // The register file is read before this cycle's writeback lands, so bypass it here.
      rs_data_d    = (wb_reg_write && wb_rd != RADDR'(REG_ZERO) && wb_rd == id_rs) ? wb_data : id_rs_data;
      rt_data_d    = (wb_reg_write && wb_rd != RADDR'(REG_ZERO) && wb_rd == id_rt) ? wb_data : id_rt_data;
      imm_d        = id_imm;
      shamt_d      = id_shamt;
      func_d       = id_func;
      alu_op_d     = id_alu_op;
      alu_src_d    = id_alu_src    & id_valid;
      mem_read_d   = id_mem_read   & id_valid;
      mem_write_d  = id_mem_write  & id_valid;
      reg_write_d  = id_reg_write  & id_valid;
      mem_to_reg_d = id_mem_to_reg & id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;  rs_q <= '0;  rt_q <= '0;  wr_reg_q <= '0;
      rs_data_q <= '0;  rt_data_q <= '0;  imm_q <= '0;  shamt_q <= '0;
      func_q <= '0;  alu_op_q <= '0;  alu_src_q <= 1'b0;  mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;  reg_write_q <= 1'b0;  mem_to_reg_q <= 1'b0;
    end else begin
      valid_q <= valid_d;  rs_q <= rs_d;  rt_q <= rt_d;  wr_reg_q <= wr_reg_d;
      rs_data_q <= rs_data_d;  rt_data_q <= rt_data_d;  imm_q <= imm_d;  shamt_q <= shamt_d;
      func_q <= func_d;  alu_op_q <= alu_op_d;  alu_src_q <= alu_src_d;  mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;  reg_write_q <= reg_write_d;  mem_to_reg_q <= mem_to_reg_d;
    end
  end

  fwd_select #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs (
    .src_i(rs_q), .latched_i(rs_data_q),
    .exm_reg_write_i(exm_reg_write), .exm_rd_i(exm_rd), .exm_result_i(exm_result),
    .wb_reg_write_i(wb_reg_write), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .fwd_o(fwd_rs)
  );

  fwd_select #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rt (
    .src_i(rt_q), .latched_i(rt_data_q),
    .exm_reg_write_i(exm_reg_write), .exm_rd_i(exm_rd), .exm_result_i(exm_result),
    .wb_reg_write_i(wb_reg_write), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .fwd_o(fwd_rt)
  );

  assign ex_valid      = valid_q;
  assign ex_in1        = fwd_rs;
  assign ex_in2        = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_shamt      = shamt_q;
  assign ex_func       = func_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_wr_reg     = wr_reg_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stalls_q, perf_flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (stall)                          perf_stalls_q  <= perf_stalls_q + 32'd1;
      if (flush && (valid_q || id_valid)) perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_stalls  = perf_stalls_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios with literal expectations, then random traffic
// checked every cycle against an instruction-level model of the EX slot.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk, reset, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt, exm_rd, wb_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, exm_result, wb_data;
  logic [5:0]  id_func;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic        flush, exm_reg_write, wb_reg_write;
  logic        stall, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [31:0] ex_in1, ex_in2, ex_store_data;
  logic [4:0]  ex_shamt, ex_wr_reg;
  logic [5:0]  ex_func;
  logic [1:0]  ex_alu_op;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stalls, perf_flushes;
  int unsigned m_stalls, m_flushes;
`endif

  id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_func(id_func), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_store_data(ex_store_data), .ex_shamt(ex_shamt), .ex_func(ex_func),
    .ex_alu_op(ex_alu_op), .ex_wr_reg(ex_wr_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
`ifdef ID_EX_PERF_EN
    , .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The instruction currently sitting in EX, as the architecture sees it.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, wr;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [1:0]  aluop;
    logic        alusrc, mr, mw, rw, m2r;
  } ex_t;

  ex_t m;
  bit  known = 0;
  int  tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Value the ALU must see for a source register, given what is in flight downstream right now.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] latched);
    if (r == 5'd0) return latched;
    if (exm_reg_write && exm_rd == r) return exm_result;
    if (wb_reg_write && wb_rd == r) return wb_data;
    return latched;
  endfunction

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_shamt = 0; id_func = 0; id_alu_op = 0; id_alu_src = 0; id_reg_dst = 0;
    id_mem_read = 0; id_mem_write = 0; id_reg_write = 0; id_mem_to_reg = 0;
    flush = 0; exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  // Check this cycle's outputs against the model, then advance one clock.
  task automatic step();
    ex_t nx;
    logic exp_stall;
    #1;
    exp_stall = !reset && m.mr && m.valid && id_valid && !flush && m.wr != 0
                && (m.wr == id_rs || m.wr == id_rt);
    if (known) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("ex_valid", 32'(ex_valid), 32'(m.valid));
      chk("ex_in1", ex_in1, newest(m.rs, m.rsd));
      chk("ex_in2", ex_in2, m.alusrc ? m.imm : newest(m.rt, m.rtd));
      chk("ex_store_data", ex_store_data, newest(m.rt, m.rtd));
      chk("ex_shamt", 32'(ex_shamt), 32'(m.shamt));
      chk("ex_func", 32'(ex_func), 32'(m.func));
      chk("ex_alu_op", 32'(ex_alu_op), 32'(m.aluop));
      chk("ex_wr_reg", 32'(ex_wr_reg), 32'(m.wr));
      chk("ex_ctrl", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg},
          {28'd0, m.mr, m.mw, m.rw, m.m2r});
    end
    nx = '0;
    if (!reset && !flush && !exp_stall) begin
      nx.valid = id_valid;
      nx.rs = id_rs;  nx.rt = id_rt;
      nx.wr = id_reg_dst ? id_rd : id_rt;
      nx.rsd = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs) ? wb_data : id_rs_data;
      nx.rtd = (wb_reg_write && wb_rd != 0 && wb_rd == id_rt) ? wb_data : id_rt_data;
      nx.imm = id_imm;  nx.shamt = id_shamt;  nx.func = id_func;  nx.aluop = id_alu_op;
      nx.alusrc = id_alu_src && id_valid;
      nx.mr = id_mem_read && id_valid;
      nx.mw = id_mem_write && id_valid;
      nx.rw = id_reg_write && id_valid;
      nx.m2r = id_mem_to_reg && id_valid;
    end
`ifdef ID_EX_PERF_EN
    if (reset) begin
      m_stalls = 0; m_flushes = 0;
    end else begin
      if (exp_stall) m_stalls++;
      if (flush && (m.valid || id_valid)) m_flushes++;
    end
`endif
    @(posedge clk);
    m = nx;
    known = 1;
    @(negedge clk);
  endtask

  task automatic load_lw4();
    idle();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd4; id_rs_data = 32'h100; id_imm = 32'd4;
    id_alu_src = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_alu_op = ALUOP_ADD;
  endtask

  task automatic dep_add4();
    idle();
    id_valid = 1; id_rs = 5'd4; id_rt = 5'd2; id_rd = 5'd5; id_rt_data = 32'd2;
    id_reg_dst = 1; id_reg_write = 1; id_alu_op = ALUOP_RTYPE; id_func = FUNC_ADD;
  endtask

  initial begin
    m = '0;
`ifdef ID_EX_PERF_EN
    m_stalls = 0; m_flushes = 0;
`endif
    idle();
    reset = 1;
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_rs_data = 32'hAA;
    id_reg_write = 1; id_mem_read = 1;
    step(); step();
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_in1", ex_in1, 32'd0);
    chk("rst_ex_ctrl", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 0;

    // add $3,$1,$2
    idle();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_rs_data = 32'd5; id_rt_data = 32'd7;
    id_reg_dst = 1; id_reg_write = 1; id_alu_op = ALUOP_RTYPE; id_func = FUNC_ADD;
    step();
    idle();
    #1;
    chk("add_in1", ex_in1, 32'd5);
    chk("add_in2", ex_in2, 32'd7);
    chk("add_wr_reg", 32'(ex_wr_reg), 32'd3);
    chk("add_reg_write", 32'(ex_reg_write), 32'd1);
    step();

    // EX/MEM beats MEM/WB
    idle();
    id_valid = 1; id_rs = 5'd3; id_rt = 5'd1; id_rs_data = 32'd1; id_reg_dst = 1; id_rd = 5'd6;
    id_reg_write = 1; id_alu_op = ALUOP_RTYPE; id_func = FUNC_SUB;
    step();
    idle();
    exm_reg_write = 1; exm_rd = 5'd3; exm_result = 32'd42;
    wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'd9;
    #1 chk("fwd_exm_prio", ex_in1, 32'd42);
    exm_reg_write = 0;
    #1 chk("fwd_wb", ex_in1, 32'd9);
    step();

    // $0 never forwards
    idle();
    id_valid = 1; id_rs = 5'd0; id_rt = 5'd1; id_rt_data = 32'd3; id_reg_write = 1; id_rd = 5'd7;
    id_reg_dst = 1; id_alu_op = ALUOP_RTYPE; id_func = FUNC_OR;
    step();
    idle();
    exm_reg_write = 1; exm_rd = 5'd0; exm_result = 32'hFFFF;
    wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'hBEEF;
    #1 chk("reg0_no_fwd", ex_in1, 32'd0);
    step();

    // Load-use: one bubble, then forward from MEM/WB
    load_lw4();
    step();
    dep_add4();
    #1 chk("lu_stall", 32'(stall), 32'd1);
    step();
    #1;
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_stall_drop", 32'(stall), 32'd0);
    step();
    idle();
    wb_reg_write = 1; wb_rd = 5'd4; wb_data = 32'h1234;
    #1;
    chk("lu_fwd_in1", ex_in1, 32'h1234);
    chk("lu_valid", 32'(ex_valid), 32'd1);
    step();

    // Flush with a pending load-use
    load_lw4();
    step();
    dep_add4();
    flush = 1;
    #1 chk("flush_stall", 32'(stall), 32'd0);
    step();
    flush = 0;
    #1;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_ctrl", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}, 32'd0);

    // Reset arriving mid-stall
    load_lw4();
    step();
    dep_add4();
    reset = 1;
    #1 chk("rst_mid_stall", 32'(stall), 32'd0);
    step();
    reset = 0;
    #1 chk("rst_mid_valid", 32'(ex_valid), 32'd0);

    // sw with immediate offset and EX/MEM-forwarded store data
    idle();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd6; id_rs_data = 32'h40; id_rt_data = 32'd3;
    id_imm = 32'd8; id_alu_src = 1; id_mem_write = 1; id_alu_op = ALUOP_ADD;
    step();
    idle();
    exm_reg_write = 1; exm_rd = 5'd6; exm_result = 32'd77;
    #1;
    chk("sw_in2", ex_in2, 32'd8);
    chk("sw_store", ex_store_data, 32'd77);
    step();

    // Random traffic, small register space to provoke hazards
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs = 5'($urandom_range(0, 7));  id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rs_data = $urandom;  id_rt_data = $urandom;  id_imm = $urandom;
      id_shamt = 5'($urandom_range(0, 31));  id_func = 6'($urandom_range(0, 63));
      id_alu_op = 2'($urandom_range(0, 2));
      id_alu_src = 1'($urandom_range(0, 1));  id_reg_dst = 1'($urandom_range(0, 1));
      id_mem_read = ($urandom_range(0, 2) == 0);  id_mem_write = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1));  id_mem_to_reg = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 9) == 0);
      exm_reg_write = 1'($urandom_range(0, 1));  exm_rd = 5'($urandom_range(0, 7));
      exm_result = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1));  wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      step();
    end
    reset = 0;
    idle();
    step();

`ifdef ID_EX_PERF_EN
    #1;
    chk("perf_stalls", perf_stalls, 32'(m_stalls));
    chk("perf_flushes", perf_flushes, 32'(m_flushes));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
